sliding_window_3x3: RTL and testbench

// - Upstream feeder for the 3x3 grayscale convolution stage.
// - Takes a raster-order pixel stream (left to right, then top to bottom) with a valid strobe.
// - Keeps two full image rows in line buffers and emits one 3x3 pixel window per "valid" output

---
 rtl/cnn_pkg.sv | 12 +
 rtl/sliding_window_3x3_line_buffer.sv | 30 +++
 rtl/sliding_window_3x3.sv | 106 ++++++++++
 tb/tb_sliding_window_3x3.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and default geometry for the grayscale CNN front end.
// The window type is also consumed by the convolution stage.
package cnn_pkg;

  localparam int unsigned PIXEL_WIDTH = 8;
  localparam int unsigned IMG_WIDTH   = 28;
  localparam int unsigned IMG_HEIGHT  = 28;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;
  typedef pixel_t [2:0][2:0]      window_t;

endpackage

// File: rtl/sliding_window_3x3_line_buffer.sv
// Single-row circular pixel store with combinational read of the old contents
// and a registered write, so a read and write to the same slot see the prior pixel.
module line_buffer #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 28,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/sliding_window_3x3.sv
// Raster-stream to 3x3 window converter: two chained line buffers feed the right-hand
// column of a shifting window; only unpadded positions raise window_valid_o.
module sliding_window_3x3 #(
  parameter int unsigned PIXEL_WIDTH = cnn_pkg::PIXEL_WIDTH,
  parameter int unsigned IMG_WIDTH   = cnn_pkg::IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT  = cnn_pkg::IMG_HEIGHT
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic [PIXEL_WIDTH-1:0]            pixel_i,
  input  logic                              pixel_valid_i,
  output logic [2:0][2:0][PIXEL_WIDTH-1:0]  window_o,
  output logic                              window_valid_o,
  output logic                              frame_done_o
);
  import cnn_pkg::*;

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);
  localparam logic [ColW-1:0] ColTwo  = ColW'(2);
  localparam logic [RowW-1:0] RowTwo  = RowW'(2);

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [2:0][2:0][PIXEL_WIDTH-1:0] win_q, win_d;
  logic valid_q, valid_d;
  logic done_q, done_d;
  logic accept;
  logic [PIXEL_WIDTH-1:0] lb1_rdata, lb0_rdata;

  // lb1 holds the previous row; its evicted pixel moves into lb0 (two rows back).
  line_buffer #(
    .Width (PIXEL_WIDTH),
    .Depth (IMG_WIDTH)
  ) u_lb1 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (accept),
    .addr_i  (col_q),
    .wdata_i (pixel_i),
    .rdata_o (lb1_rdata)
  );

  line_buffer #(
    .Width (PIXEL_WIDTH),
    .Depth (IMG_WIDTH)
  ) u_lb0 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (accept),
    .addr_i  (col_q),
    .wdata_i (lb1_rdata),
    .rdata_o (lb0_rdata)
  );

  always_comb begin
    accept  = pixel_valid_i && !clear_i;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = accept && (row_q >= RowTwo) && (col_q >= ColTwo);
    done_d  = accept && (row_q == RowLast) && (col_q == ColLast);
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[2][2] = pixel_i;
      win_d[1][2] = lb1_rdata;
      win_d[0][2] = lb0_rdata;
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign window_o       = win_q;
  assign window_valid_o = valid_q;
  assign frame_done_o   = done_q;

endmodule

// File: tb/tb_sliding_window_3x3.sv
// Scoreboard bench: a frame-image reference model pushes expected windows as pixels are
// issued; a negedge monitor pops and compares whenever the DUT presents a window.
module tb_sliding_window_3x3;

  typedef logic [2:0][2:0][7:0] win_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic clear_i = 1'b0;
  logic [7:0] pixel_i = '0;
  logic pixel_valid_i = 1'b0;
  win_t window_o;
  logic window_valid_o, frame_done_o;

  logic big_valid = 1'b0;
  logic [7:0] big_pixel = '0;
  win_t big_window;
  logic big_wvalid, big_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sliding_window_3x3 #(
    .PIXEL_WIDTH (8),
    .IMG_WIDTH   (4),
    .IMG_HEIGHT  (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .pixel_i        (pixel_i),
    .pixel_valid_i  (pixel_valid_i),
    .window_o       (window_o),
    .window_valid_o (window_valid_o),
    .frame_done_o   (frame_done_o)
  );

  sliding_window_3x3 dut_big (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .clear_i        (1'b0),
    .pixel_i        (big_pixel),
    .pixel_valid_i  (big_valid),
    .window_o       (big_window),
    .window_valid_o (big_wvalid),
    .frame_done_o   (big_done)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the current frame as a 2D image plus the raster position.
  int img[4][4];
  int mr = 0, mc = 0;
  win_t exp_win_q[$];
  bit   exp_done_q[$];
  win_t obs_q[$];
  int   n_win = 0;
  int   n_done = 0;

  function automatic win_t win3(input int base);
    win_t w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[r][c] = 8'(base + r * 4 + c);
    return w;
  endfunction

  task automatic model_accept(input int p);
    win_t w;
    img[mr][mc] = p;
    if (mr >= 2 && mc >= 2) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[r][c] = 8'(img[mr - 2 + r][mc - 2 + c]);
      exp_win_q.push_back(w);
      exp_done_q.push_back(mr == 3 && mc == 3);
    end
    if (mc == 3) begin
      mc = 0;
      mr = (mr == 3) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  task automatic send_pix(input int p, input int gap);
    repeat (gap) begin
      pixel_valid_i = 1'b0;
      pixel_i = 8'($urandom);
      @(posedge clk); #1;
    end
    pixel_i = 8'(p);
    pixel_valid_i = 1'b1;
    model_accept(p);
    @(posedge clk); #1;
    pixel_valid_i = 1'b0;
  endtask

  task automatic send_frame(input int base, input int maxgap);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        send_pix(base + r * 4 + c, (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)));
  endtask

  task automatic begin_test();
    obs_q.delete();
    n_win = 0;
    n_done = 0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 72'(exp_win_q.size()), 72'(0));
  endtask

  // Accept seen at the last rising edge; a valid window may only follow one.
  logic acc_d;
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) acc_d <= 1'b0;
    else         acc_d <= pixel_valid_i & ~clear_i;
  end

  always @(negedge clk) begin
    if (window_valid_o) begin
      chk("valid_after_accept", 72'(acc_d), 72'(1));
      if (exp_win_q.size() == 0) begin
        chk("unexpected_window", 72'(1), 72'(0));
      end else begin
        chk("window", window_o, exp_win_q.pop_front());
        chk("frame_done", 72'(frame_done_o), 72'(exp_done_q.pop_front()));
      end
      obs_q.push_back(window_o);
      n_win++;
      if (frame_done_o) n_done++;
    end else if (frame_done_o) begin
      chk("done_without_window", 72'(1), 72'(0));
    end
  end

  int big_win = 0, big_ndone = 0;
  always @(negedge clk) begin
    if (big_wvalid) big_win++;
    if (big_done) big_ndone++;
  end

  initial begin
    #1;
    chk("reset_window", window_o, 72'(0));
    chk("reset_valid", 72'(window_valid_o), 72'(0));
    chk("reset_done", 72'(frame_done_o), 72'(0));
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Contiguous frame
    begin_test();
    send_frame(0, 0);
    settle();
    chk("contig_count", 72'(n_win), 72'(4));
    chk("contig_done_pulses", 72'(n_done), 72'(1));
    if (obs_q.size() == 4) begin
      chk("contig_first", obs_q[0], win3(0));
      chk("rowwrap_after_px14", obs_q[2], win3(4));
      chk("contig_last", obs_q[3], win3(5));
    end else begin
      chk("contig_obs_size", 72'(obs_q.size()), 72'(4));
    end

    // Same frame with random gaps
    begin_test();
    send_frame(0, 5);
    settle();
    chk("gap_count", 72'(n_win), 72'(4));
    if (obs_q.size() == 4) begin
      chk("gap_first", obs_q[0], win3(0));
      chk("gap_last", obs_q[3], win3(5));
    end

    // Back-to-back frames, second offset by 100
    begin_test();
    send_frame(0, 0);
    send_frame(100, 0);
    settle();
    chk("b2b_count", 72'(n_win), 72'(8));
    chk("b2b_done_pulses", 72'(n_done), 72'(2));
    if (obs_q.size() == 8) chk("b2b_frame2_first", obs_q[4], win3(100));

    // Clear together with a valid pixel after pixel 9
    begin_test();
    for (int i = 0; i < 10; i++) send_pix(i, 0);
    pixel_i = 8'd10;
    pixel_valid_i = 1'b1;
    clear_i = 1'b1;
    mr = 0;
    mc = 0;
    @(posedge clk); #1;
    clear_i = 1'b0;
    pixel_valid_i = 1'b0;
    chk("clear_no_window", 72'(n_win), 72'(0));
    send_frame(0, 2);
    settle();
    chk("clear_count", 72'(n_win), 72'(4));

    // Asynchronous reset mid-frame after pixel 11
    begin_test();
    for (int i = 0; i < 12; i++) send_pix(i, 0);
    @(negedge clk); #1;
    chk("prereset_drained", 72'(exp_win_q.size()), 72'(0));
    rst_ni = 1'b0;
    #1;
    chk("midreset_window", window_o, 72'(0));
    chk("midreset_valid", 72'(window_valid_o), 72'(0));
    chk("midreset_done", 72'(frame_done_o), 72'(0));
    mr = 0;
    mc = 0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    begin_test();
    send_frame(0, 1);
    settle();
    chk("postreset_count", 72'(n_win), 72'(4));

    // Default 28x28 ramp
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) begin
        big_pixel = 8'((r + c) % 256);
        big_valid = 1'b1;
        @(posedge clk); #1;
      end
    end
    big_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("big_windows", 72'(big_win), 72'(676));
    chk("big_done_pulses", 72'(big_ndone), 72'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
